// File: rtl/ieee_conv_sched.sv
// Shared fixed-point to IEEE-754 single converter for two requesters.
// Round-robin grant, one-bit-per-cycle normalisation, valid/ready result port.
module ieee_conv_sched #(
   parameter int unsigned INT_W    = 5,
   parameter int unsigned FRAC_W   = 5,
   parameter int unsigned EXP_BIAS = 127
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [INT_W-1:0]  a_in1,
   input  logic [FRAC_W-1:0] a_in2,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [INT_W-1:0]  b_in1,
   input  logic [FRAC_W-1:0] b_in2,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [31:0]       out,
   output logic              res_id,
   output logic              busy
);

   localparam int unsigned W        = INT_W + FRAC_W;
   localparam int unsigned MANT_PAD = 24 - W;
   localparam logic [7:0]  EXP_INIT = 8'(EXP_BIAS + INT_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_NORM = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t         state;
   logic [W-1:0]   val;
   logic [7:0]     exp_q;
   logic           last_grant;   // 0 = A, 1 = B
   logic           grant_any;
   logic           grant_b;
   logic [22:0]    mant;

   // B wins when alone, or in contention when A was served last.
   assign grant_any = (state == S_IDLE) && !rst && (a_valid || b_valid);
   assign grant_b   = b_valid && (!a_valid || !last_grant);
   assign a_ready   = grant_any && !grant_b;
   assign b_ready   = grant_any && grant_b;
   assign busy      = (state != S_IDLE);

   // Hidden leading one dropped, fraction left-aligned into 23 mantissa bits.
   assign mant = 23'(val[W-2:0]) << MANT_PAD;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         val        <= '0;
         exp_q      <= '0;
         last_grant <= 1'b1;
         res_valid  <= 1'b0;
         out        <= '0;
         res_id     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (a_ready || b_ready) begin
                  val        <= b_ready ? {b_in1, b_in2} : {a_in1, a_in2};
                  exp_q      <= EXP_INIT;
                  res_id     <= b_ready;
                  last_grant <= b_ready;
                  state      <= S_NORM;
               end
            end
            S_NORM: begin
               if (val == '0) begin
                  out       <= '0;
                  res_valid <= 1'b1;
                  state     <= S_HOLD;
               end else if (val[W-1]) begin
                  out       <= {1'b0, exp_q, mant};
                  res_valid <= 1'b1;
                  state     <= S_HOLD;
               end else begin
                  val   <= val << 1;
                  exp_q <= exp_q - 8'd1;
               end
            end
            S_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ieee_conv_sched.sv
// Self-checking bench for ieee_conv_sched: directed cases plus randomized
// requests against a real-arithmetic reference of the conversion and grant order.
module tb_ieee_conv_sched;

   localparam int unsigned INT_W  = 5;
   localparam int unsigned FRAC_W = 5;
   localparam int unsigned W      = INT_W + FRAC_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              a_valid = 1'b0;
   logic              a_ready;
   logic [INT_W-1:0]  a_in1 = '0;
   logic [FRAC_W-1:0] a_in2 = '0;
   logic              b_valid = 1'b0;
   logic              b_ready;
   logic [INT_W-1:0]  b_in1 = '0;
   logic [FRAC_W-1:0] b_in2 = '0;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [31:0]       dout;
   logic              res_id;
   logic              busy;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic last_g = 1'b1;   // model of who was served last: 0 = A, 1 = B

   ieee_conv_sched #(.INT_W(INT_W), .FRAC_W(FRAC_W), .EXP_BIAS(127)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_in1(a_in1), .a_in2(a_in2),
      .b_valid(b_valid), .b_ready(b_ready), .b_in1(b_in1), .b_in2(b_in2),
      .res_valid(res_valid), .res_ready(res_ready),
      .out(dout), .res_id(res_id), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Operand value in real arithmetic, re-encoded from the double-precision image.
   function automatic logic [31:0] ref_float(input int unsigned i1, input int unsigned i2);
      real         r;
      logic [63:0] d;
      int          e;
      r = real'(i1) + real'(i2) / real'(1 << FRAC_W);
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      return {1'b0, e[7:0], d[51:29]};
   endfunction

   function automatic int ref_lat(input int unsigned i1, input int unsigned i2);
      int unsigned v;
      int          k;
      v = (i1 << FRAC_W) | i2;
      if (v == 0) return 2;
      k = 0;
      for (int b = W - 1; b >= 0; b--) begin
         if (v[b]) break;
         k++;
      end
      return 2 + k;
   endfunction

   // Wait for the result of a request handshaken in the previous cycle; checks it.
   task automatic wait_result(input logic id, input logic [31:0] exp_o, input int exp_l);
      int n;
      n = 1;
      @(negedge clk);
      while (!res_valid && n < 64) begin
         check("busy", 32'(busy), 32'd1);
         @(negedge clk);
         n++;
      end
      check("res_valid", 32'(res_valid), 32'd1);
      check("latency", 32'(n), 32'(exp_l));
      check("out", dout, exp_o);
      check("res_id", 32'(res_id), 32'(id));
   endtask

   task automatic req_one(input logic id, input logic [4:0] i1, input logic [4:0] i2,
                          input int hold, output logic [31:0] got);
      logic [31:0] held;
      logic        hid;
      tick();
      if (id) begin b_valid = 1'b1; b_in1 = i1; b_in2 = i2; end
      else    begin a_valid = 1'b1; a_in1 = i1; a_in2 = i2; end
      res_ready = (hold == 0);
      @(negedge clk);
      check("grant", 32'({a_ready, b_ready}), id ? 32'd1 : 32'd2);
      last_g = id;
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
      wait_result(id, ref_float(i1, i2), ref_lat(i1, i2));
      got = dout;
      if (hold > 0) begin
         held = dout;
         hid  = res_id;
         repeat (hold) begin
            tick();
            a_valid = 1'b1; b_valid = 1'b1;
            a_in1 = 5'($urandom); a_in2 = 5'($urandom);
            b_in1 = 5'($urandom); b_in2 = 5'($urandom);
            @(negedge clk);
            check("bp_ready", 32'({a_ready, b_ready}), 32'd0);
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_out", dout, held);
            check("bp_id", 32'(res_id), 32'(hid));
         end
         tick();
         a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b1;
         @(negedge clk);
         check("rel_valid", 32'(res_valid), 32'd1);
      end
      tick();
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(res_valid), 32'd0);
   endtask

   // Both requesters keep asking; grants must strictly alternate.
   task automatic contend(input int n_each);
      int          ca, cb;
      logic        g;
      logic [4:0]  i1, i2;
      ca = 0; cb = 0;
      tick();
      res_ready = 1'b1;
      a_valid = 1'b1; a_in1 = 5'($urandom); a_in2 = 5'($urandom);
      b_valid = 1'b1; b_in1 = 5'($urandom); b_in2 = 5'($urandom);
      while (ca < n_each || cb < n_each) begin
         if (ca < n_each && cb < n_each) g = ~last_g;
         else                            g = (ca < n_each) ? 1'b0 : 1'b1;
         @(negedge clk);
         check("cont_grant", 32'({a_ready, b_ready}), g ? 32'd1 : 32'd2);
         i1 = g ? b_in1 : a_in1;
         i2 = g ? b_in2 : a_in2;
         last_g = g;
         if (g) cb++; else ca++;
         tick();
         if (g) begin
            if (cb < n_each) begin b_in1 = 5'($urandom); b_in2 = 5'($urandom); end
            else b_valid = 1'b0;
         end else begin
            if (ca < n_each) begin a_in1 = 5'($urandom); a_in2 = 5'($urandom); end
            else a_valid = 1'b0;
         end
         wait_result(g, ref_float(i1, i2), ref_lat(i1, i2));
         tick();
      end
   endtask

   initial begin
      logic [31:0] got;

      // Reset: readies held low even with both valids up.
      rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
      tick(); tick();
      @(negedge clk);
      check("rst_ready", 32'({a_ready, b_ready}), 32'd0);
      tick();
      rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
      last_g = 1'b1;
      @(negedge clk);
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_out", dout, 32'd0);
      check("rst_id", 32'(res_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Directed conversions.
      req_one(1'b0, 5'd6, 5'd7, 0, got);
      check("dir_6_7", got, 32'h40C70000);
      req_one(1'b1, 5'd31, 5'd31, 0, got);
      check("dir_31_31", got, 32'h41FFC000);
      req_one(1'b0, 5'd0, 5'd1, 0, got);
      check("dir_0_1", got, 32'h3D000000);
      req_one(1'b0, 5'd0, 5'd0, 0, got);
      check("dir_zero", got, 32'h00000000);

      // Contention and back-pressure.
      contend(4);
      req_one(1'b1, 5'($urandom), 5'($urandom), 5, got);
      contend(2);

      // Reset mid-normalisation aborts the request.
      tick();
      a_valid = 1'b1; a_in1 = 5'd0; a_in2 = 5'd1;
      @(negedge clk);
      check("mid_grant", 32'({a_ready, b_ready}), 32'd2);
      tick();
      a_valid = 1'b0;
      tick(); tick();
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      tick();
      rst = 1'b1; a_valid = 1'b1;
      @(negedge clk);
      check("mid_rst_ready", 32'(a_ready), 32'd0);
      tick();
      rst = 1'b0; a_valid = 1'b0;
      last_g = 1'b1;
      @(negedge clk);
      check("mid_idle_busy", 32'(busy), 32'd0);
      check("mid_idle_valid", 32'(res_valid), 32'd0);
      req_one(1'b0, 5'd0, 5'd1, 0, got);
      check("mid_retry", got, 32'h3D000000);
      contend(2);

      // Randomized single requests with random back-pressure.
      for (int i = 0; i < 25; i++) begin
         req_one(1'($urandom), 5'($urandom), 5'($urandom), int'($urandom_range(0, 3)), got);
      end
      contend(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
